// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared ALU opcodes, control-word bit positions and FSM states for execute.
package riscv_pkg;

   typedef enum logic [3:0] {
      ALU_ADD  = 4'b0000,
      ALU_SUB  = 4'b0001,
      ALU_AND  = 4'b0010,
      ALU_OR   = 4'b0011,
      ALU_XOR  = 4'b0100,
      ALU_SLL  = 4'b0101,
      ALU_SRL  = 4'b0110,
      ALU_SRA  = 4'b0111,
      ALU_SLT  = 4'b1000,
      ALU_SLTU = 4'b1001
   } alu_op_e;

   // CtrlSig = {ALUControl[3:0], ALUSrc, MemWrite, RegWrite, ResultSrc}
   localparam int CTRL_ALUCTRL_MSB = 7;
   localparam int CTRL_ALUCTRL_LSB = 4;
   localparam int CTRL_ALUSRC      = 3;
   localparam int CTRL_MEMWRITE    = 2;
   localparam int CTRL_REGWRITE    = 1;
   localparam int CTRL_RESULTSRC   = 0;

   localparam int IR_RD_LSB  = 7;
   localparam int IR_RS1_LSB = 15;
   localparam int IR_RS2_LSB = 20;

   typedef enum logic {
      ST_EMPTY = 1'b0,
      ST_FULL  = 1'b1
   } exec_state_e;

endpackage

// File: rtl/execute_alu.sv
// rtl/execute_alu.sv - combinational ALU; unknown opcodes produce zero.
import riscv_pkg::*;

module alu (
   input  logic [3:0]  op,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic [31:0] y
);

   logic [4:0] shamt;

   assign shamt = b[4:0];

   always_comb begin
      y = 32'd0;
      case (op)
         ALU_ADD:  y = a + b;
         ALU_SUB:  y = a - b;
         ALU_AND:  y = a & b;
         ALU_OR:   y = a | b;
         ALU_XOR:  y = a ^ b;
         ALU_SLL:  y = a << shamt;
         ALU_SRL:  y = a >> shamt;
         ALU_SRA:  y = $unsigned($signed(a) >>> shamt);
         ALU_SLT:  y = {31'd0, $signed(a) < $signed(b)};
         ALU_SLTU: y = {31'd0, a < b};
         default:  y = 32'd0;
      endcase
   end

endmodule

// File: rtl/execute.sv
// rtl/execute.sv - execute stage: one-deep output register with valid/ready handshake.
// Optional EXEC_FWD_EN adds result forwarding from the previously accepted instruction.
import riscv_pkg::*;

module execute (
   input  logic        clk1,
   input  logic        rst,
   input  logic [31:0] in_IR,
   input  logic [31:0] A,
   input  logic [31:0] B,
   input  logic [31:0] Imm,
   input  logic [7:0]  CtrlSig,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic        out_ready,
   output logic        out_valid,
   output logic [31:0] alu_result,
   output logic [31:0] store_data,
   output logic [31:0] out_IR,
   output logic [2:0]  out_ctrl
);

   exec_state_e state;
   exec_state_e state_next;
   logic        accept;
   logic [31:0] op_a;
   logic [31:0] op_b;
   logic [31:0] op2;
   logic [31:0] alu_y;

`ifdef EXEC_FWD_EN
   logic [4:0]  last_rd;
   logic [31:0] last_result;
   logic        last_we;
   logic [4:0]  rs1;
   logic [4:0]  rs2;

   assign rs1 = in_IR[IR_RS1_LSB +: 5];
   assign rs2 = in_IR[IR_RS2_LSB +: 5];

   // x0 is never forwarded: writes to it are architecturally discarded
   always_comb begin
      op_a = A;
      op_b = B;
      if (last_we && (last_rd != 5'd0) && (last_rd == rs1))
         op_a = last_result;
      if (last_we && (last_rd != 5'd0) && (last_rd == rs2))
         op_b = last_result;
   end

   always_ff @(posedge clk1) begin
      if (rst) begin
         last_rd     <= 5'd0;
         last_result <= 32'd0;
         last_we     <= 1'b0;
      end else if (accept) begin
         last_rd     <= in_IR[IR_RD_LSB +: 5];
         last_result <= alu_y;
         last_we     <= CtrlSig[CTRL_REGWRITE];
      end
   end
`else
   assign op_a = A;
   assign op_b = B;
`endif

   assign op2 = CtrlSig[CTRL_ALUSRC] ? Imm : op_b;

   alu u_alu (
      .op (CtrlSig[CTRL_ALUCTRL_MSB:CTRL_ALUCTRL_LSB]),
      .a  (op_a),
      .b  (op2),
      .y  (alu_y)
   );

   always_ff @(posedge clk1) begin
      if (rst)
         state <= ST_EMPTY;
      else
         state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         ST_EMPTY: if (accept) state_next = ST_FULL;
         ST_FULL:  if (out_ready && !in_valid) state_next = ST_EMPTY;
         default:  state_next = ST_EMPTY;
      endcase
   end

   // A full register still accepts when the consumer drains it in the same cycle
   always_comb begin
      in_ready  = (state == ST_EMPTY) | out_ready;
      out_valid = (state == ST_FULL);
      accept    = in_valid & in_ready;
   end

   always_ff @(posedge clk1) begin
      if (rst) begin
         alu_result <= 32'd0;
         store_data <= 32'd0;
         out_IR     <= 32'd0;
         out_ctrl   <= 3'd0;
      end else if (accept) begin
         alu_result <= alu_y;
         store_data <= op_b;
         out_IR     <= in_IR;
         out_ctrl   <= CtrlSig[CTRL_MEMWRITE:CTRL_RESULTSRC];
      end
   end

endmodule
